// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing for the burst reader and its skid buffer.
package fifo_burst_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer between the FIFO pop and the output stream.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occ
);
  logic [DATA_WIDTH-1:0] d0, d1;
  logic                  l0, l1;
  logic                  pop;

  assign out_valid = (occ != '0);
  assign out_data  = d0;
  assign out_last  = l0 & out_valid;
  assign pop       = out_valid & out_ready;

  // Entry 0 is always the head; push into a full buffer never happens.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      d0 <= '0; d1 <= '0; l0 <= 1'b0; l1 <= 1'b0; occ <= '0;
    end else if (flush) begin
      l0 <= 1'b0; l1 <= 1'b0; occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) begin d0 <= push_data; l0 <= push_last; end
          else           begin d1 <= push_data; l1 <= push_last; end
          occ <= occ + 1'b1;
        end
        2'b01: begin
          d0 <= d1; l0 <= l1;
          occ <= occ - 1'b1;
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            d0 <= push_data; l0 <= push_last;
          end else begin
            d0 <= d1; l0 <= l1;
            d1 <= push_data; l1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains burst_len words from the sample FIFO onto a valid/ready stream,
// counting mid-burst underruns.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 16,
  parameter int UNDERRUN_WIDTH = 8
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst_n,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      burst_len,
  input  logic                      abort,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic [UNDERRUN_WIDTH-1:0] underrun_count
);
  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len, pop_cnt;
  logic [OCC_W-1:0]     occ;
  logic                 start_ok, last_pop, acc, underrun_hit;

  assign start_ok = start & ~abort & (state == IDLE);
  assign last_pop = (pop_cnt == len - LEN_WIDTH'(1));
  assign acc      = m_valid & m_ready;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start && burst_len != '0)  state_nxt = RUN;
        RUN:     if (fifo_rd_en && last_pop)    state_nxt = DRAIN;
        DRAIN:   if (acc && m_last)             state_nxt = IDLE;
        default:                                state_nxt = IDLE;
      endcase
    end
  end

  // Pop gating uses only registered state, so m_ready never reaches fifo_rd_en.
  always_comb begin
    fifo_rd_en   = 1'b0;
    underrun_hit = 1'b0;
    busy         = (state != IDLE);
    if (state == RUN && occ < OCC_W'(SKID_DEPTH) && pop_cnt < len) begin
      fifo_rd_en   = ~fifo_empty & ~abort;
      underrun_hit = fifo_empty;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      len <= '0; pop_cnt <= '0; underrun_count <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        len            <= burst_len;
        pop_cnt        <= '0;
        underrun_count <= '0;
        done           <= (burst_len == '0);
      end else if (!abort) begin
        if (fifo_rd_en) pop_cnt <= pop_cnt + 1'b1;
        if (underrun_hit && underrun_count != '1)
          underrun_count <= underrun_count + 1'b1;
        if (state == DRAIN && acc && m_last) done <= 1'b1;
      end
    end
  end

  fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .flush     (abort),
    .push      (fifo_rd_en),
    .push_data (fifo_rd_data),
    .push_last (last_pop),
    .out_data  (m_data),
    .out_last  (m_last),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .occ       (occ)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: behavioural show-ahead FIFO feeding the reader, stream monitor.
module tb_fifo_burst_reader;
  localparam int DW = 16, LW = 16, UW = 8;

  logic          rd_clk = 1'b0, rd_rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] fifo_rd_data, m_data;
  logic          fifo_empty, fifo_rd_en, m_valid, m_last, busy, done;
  logic [UW-1:0] underrun_count;
  int checks = 0, failures = 0;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .UNDERRUN_WIDTH(UW)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .start(start), .burst_len(burst_len),
    .abort(abort), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done), .underrun_count(underrun_count)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model
  logic [DW-1:0] mem [0:1023];
  logic [9:0]    wr_ptr = '0, rd_ptr = '0;
  logic          push = 1'b0, fflush = 1'b0;
  logic [DW-1:0] push_data = '0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr];
  always @(posedge rd_clk) begin
    if (fflush)          rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1'b1;
    if (push) begin mem[wr_ptr] <= push_data; wr_ptr <= wr_ptr + 1'b1; end
  end

  // Stream monitor
  logic [DW:0] beat_q[$];
  logic [DW:0] held = '0;
  logic        stalled = 1'b0, mon_clr = 1'b0;
  int pops = 0, accs = 0, done_cnt = 0, max_ahead = 0, stall_viol = 0;
  always @(posedge rd_clk) begin
    if (mon_clr) begin
      beat_q.delete(); pops = 0; accs = 0; done_cnt = 0; max_ahead = 0;
      stall_viol = 0; stalled = 1'b0;
    end else begin
      if (stalled && (!m_valid || {m_last, m_data} !== held)) stall_viol++;
      stalled = m_valid && !m_ready;
      held    = {m_last, m_data};
      if (m_valid && m_ready) begin beat_q.push_back({m_last, m_data}); accs++; end
      if (fifo_rd_en) pops++;
      if (done) done_cnt++;
      if (pops - accs > max_ahead) max_ahead = pops - accs;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge rd_clk); push = 1'b1; push_data = base + DW'(i);
    end
    @(negedge rd_clk); push = 1'b0;
  endtask

  task automatic fifo_flush();
    @(negedge rd_clk); fflush = 1'b1;
    @(negedge rd_clk); fflush = 1'b0;
  endtask

  task automatic clr_mon();
    @(negedge rd_clk); mon_clr = 1'b1;
    @(negedge rd_clk); mon_clr = 1'b0;
  endtask

  task automatic go(input int len);
    start = 1'b1; burst_len = LW'(len);
    @(negedge rd_clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (!done && n < max_cyc) begin @(negedge rd_clk); n++; end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] en_e, vld_e, last_e, done_e;
    logic [3:0] pat;
    int n, p;

    // Reset values
    tick(2);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {16'd0, m_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    chk("rst_underrun", {24'd0, underrun_count}, 0);
    rd_rst_n = 1'b1;

    // 1: reset mid-burst, then a clean len=2 burst
    m_ready = 1'b1;
    preload(8, 16'h0010);
    go(8);
    n = 0;
    while (beat_q.size() < 3 && n < 40) begin @(negedge rd_clk); n++; end
    chk("t1_three_beats", beat_q.size(), 3);
    rd_rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", {31'd0, m_valid}, 0);
    chk("t1_rst_busy", {31'd0, busy}, 0);
    chk("t1_rst_done", {31'd0, done}, 0);
    chk("t1_rst_rd_en", {31'd0, fifo_rd_en}, 0);
    @(negedge rd_clk); rd_rst_n = 1'b1;
    fifo_flush(); clr_mon();
    preload(2, 16'h0020);
    go(2);
    wait_done(20, "t1_done");
    chk("t1_count", beat_q.size(), 2);
    chk("t1_beat0", {15'd0, beat_q[0]}, {15'd0, 1'b0, 16'h0020});
    chk("t1_beat1", {15'd0, beat_q[1]}, {15'd0, 1'b1, 16'h0021});

    // 2: cycle-exact streaming of 4 preloaded words
    clr_mon();
    preload(4, 16'h0001);
    go(4);
    en_e = 6'b001111; vld_e = 6'b011110; last_e = 6'b010000; done_e = 6'b100000;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("t2_rd_en_c%0d", c), {31'd0, fifo_rd_en}, {31'd0, en_e[c-1]});
      chk($sformatf("t2_valid_c%0d", c), {31'd0, m_valid}, {31'd0, vld_e[c-1]});
      chk($sformatf("t2_last_c%0d", c), {31'd0, m_last}, {31'd0, last_e[c-1]});
      chk($sformatf("t2_done_c%0d", c), {31'd0, done}, {31'd0, done_e[c-1]});
      if (vld_e[c-1]) chk($sformatf("t2_data_c%0d", c), {16'd0, m_data}, c - 1);
      @(negedge rd_clk);
    end
    chk("t2_underrun", {24'd0, underrun_count}, 0);

    // 3: backpressure with ready pattern 1,0,0,1
    clr_mon();
    preload(6, 16'h0030);
    pat = 4'b1001;
    go(6);
    n = 0;
    while (!done && n < 80) begin m_ready = pat[n % 4]; @(negedge rd_clk); n++; end
    chk("t3_done", {31'd0, done}, 1);
    m_ready = 1'b1;
    chk("t3_count", beat_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_beat%0d", i), {15'd0, beat_q[i]},
          {15'd0, (i == 5), 16'h0030 + 16'(i)});
    chk("t3_stall_stable", stall_viol, 0);
    chk("t3_max_ahead_le2", {31'd0, max_ahead <= 2}, 1);
    chk("t3_pops", pops, 6);

    // 4: underrun while FIFO is empty for four cycles
    clr_mon();
    preload(2, 16'h0040);
    go(5);
    tick(5);
    push = 1'b1; push_data = 16'h0042; @(negedge rd_clk);
    push_data = 16'h0043; @(negedge rd_clk);
    push_data = 16'h0044; @(negedge rd_clk);
    push = 1'b0;
    wait_done(30, "t4_done");
    chk("t4_underrun", {24'd0, underrun_count}, 4);
    chk("t4_count", beat_q.size(), 5);
    chk("t4_beat3", {15'd0, beat_q[3]}, {15'd0, 1'b0, 16'h0043});
    chk("t4_beat4", {15'd0, beat_q[4]}, {15'd0, 1'b1, 16'h0044});

    // 4b: long starvation saturates, abort retains the count
    clr_mon();
    go(300);
    tick(300);
    chk("t4_saturate", {24'd0, underrun_count}, 32'hFF);
    abort = 1'b1; @(negedge rd_clk); abort = 1'b0;
    chk("t4_abort_busy", {31'd0, busy}, 0);
    chk("t4_retained", {24'd0, underrun_count}, 32'hFF);

    // 5: abort with a word held in the buffer, then a zero-length start
    clr_mon();
    preload(6, 16'h0050);
    go(6);
    n = 0;
    while (beat_q.size() < 2 && n < 40) begin @(negedge rd_clk); n++; end
    chk("t5_two_beats", beat_q.size(), 2);
    m_ready = 1'b0; abort = 1'b1;
    #1;
    chk("t5_abort_rd_en", {31'd0, fifo_rd_en}, 0);
    @(negedge rd_clk); abort = 1'b0;
    chk("t5_valid", {31'd0, m_valid}, 0);
    chk("t5_last", {31'd0, m_last}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    p = pops;
    m_ready = 1'b1;
    tick(5);
    chk("t5_no_pops", pops, p);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_beats", beat_q.size(), 2);
    fifo_flush(); clr_mon();
    go(0);
    chk("t5_len0_done", {31'd0, done}, 1);
    chk("t5_len0_busy", {31'd0, busy}, 0);
    @(negedge rd_clk);
    chk("t5_len0_done_off", {31'd0, done}, 0);
    tick(2);
    chk("t5_len0_beats", beat_q.size(), 0);
    chk("t5_len0_pops", pops, 0);

    // 6: start while busy ignored; start+abort in IDLE ignored
    clr_mon();
    preload(9, 16'h0060);
    start = 1'b1; burst_len = 16'd3; @(negedge rd_clk);
    burst_len = 16'd9; @(negedge rd_clk);
    start = 1'b0;
    wait_done(30, "t6_done");
    chk("t6_count", beat_q.size(), 3);
    chk("t6_beat2", {15'd0, beat_q[2]}, {15'd0, 1'b1, 16'h0062});
    chk("t6_pops", pops, 3);
    tick(3);
    chk("t6_idle", {31'd0, busy}, 0);
    chk("t6_done_cnt", done_cnt, 1);
    fifo_flush(); clr_mon();
    preload(2, 16'h0070);
    start = 1'b1; abort = 1'b1; burst_len = 16'd2; @(negedge rd_clk);
    start = 1'b0; abort = 1'b0;
    chk("t6_sa_busy", {31'd0, busy}, 0);
    tick(5);
    chk("t6_sa_pops", pops, 0);
    chk("t6_sa_beats", beat_q.size(), 0);
    chk("t6_sa_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
